pll_lock_sequencer: RTL and testbench

PLL_LOCK_SEQUENCER -- requirements
Module: pll_lock_sequencer

---
 rtl/pll_lock_sequencer_if.sv | 41 ++++
 rtl/pll_lock_sequencer.sv | 178 +++++++++++++++++
 tb/tb_pll_lock_sequencer.sv | 305 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pll_lock_sequencer_if.sv
// PLL lock sequencer bus: the PLL-facing control/status signals plus the divider-reload
// handshake, bundled so the sequencer and its environment share one connection.
//   pll_lock              PLL LOCK, asynchronous to clkin
//   pll_reset             PLL RESET drive, active-high
//   pll_idsel/fbdsel/odsel  6-bit dynamic divider selects to the PLL
//   cfg_req               level request to load new dividers, held until cfg_ack
//   cfg_idsel/fbdsel/odsel  requested divider selects, stable while cfg_req is high
//   cfg_ack               one-cycle acceptance pulse
//   rst_out               active-high downstream reset
//   locked                high only while the PLL is running locked
//   fail                  sticky lock-failure flag
//   retry_cnt             failed lock attempts in the current sequence
// slave: the sequencer side. master: the environment driving the PLL lock and requests.
interface pll_lock_sequencer_if;
   logic       pll_lock;
   logic       pll_reset;
   logic [5:0] pll_idsel;
   logic [5:0] pll_fbdsel;
   logic [5:0] pll_odsel;
   logic       cfg_req;
   logic [5:0] cfg_idsel;
   logic [5:0] cfg_fbdsel;
   logic [5:0] cfg_odsel;
   logic       cfg_ack;
   logic       rst_out;
   logic       locked;
   logic       fail;
   logic [1:0] retry_cnt;

   modport slave (
      input  pll_lock, cfg_req, cfg_idsel, cfg_fbdsel, cfg_odsel,
      output pll_reset, pll_idsel, pll_fbdsel, pll_odsel, cfg_ack, rst_out, locked, fail,
             retry_cnt
   );

   modport master (
      output pll_lock, cfg_req, cfg_idsel, cfg_fbdsel, cfg_odsel,
      input  pll_reset, pll_idsel, pll_fbdsel, pll_odsel, cfg_ack, rst_out, locked, fail,
             retry_cnt
   );
endinterface

// File: rtl/pll_lock_sequencer.sv
// PLL lock sequencer: pulses PLL reset, waits for a synchronized lock, requires the lock to
// stay up for a stable window before releasing the downstream reset, retries on timeout and
// parks in a sticky failure state after too many attempts. New divider settings are only
// accepted while running or failed, and each acceptance restarts the whole sequence.
// Ports:
//   clkin  27 MHz reference clock, all logic on its rising edge
//   reset  asynchronous active-high reset
//   bus    pll_lock_sequencer_if.slave (PLL control/status and divider-reload handshake)
// All outputs are registered; the status outputs are decoded from the next state so they
// line up with the state register.
module pll_lock_sequencer #(
   parameter int unsigned RESET_PULSE_CYCLES  = 27,
   parameter int unsigned LOCK_STABLE_CYCLES  = 2700,
   parameter int unsigned LOCK_TIMEOUT_CYCLES = 27000,
   parameter int unsigned MAX_RETRIES         = 3,
   parameter logic [5:0]  INIT_IDSEL          = 6'd0,
   parameter logic [5:0]  INIT_FBDSEL         = 6'd0,
   parameter logic [5:0]  INIT_ODSEL          = 6'd0
) (
   input logic                  clkin,
   input logic                  reset,
   pll_lock_sequencer_if.slave  bus
);

   localparam int unsigned MaxAb  = (RESET_PULSE_CYCLES > LOCK_STABLE_CYCLES) ?
                                    RESET_PULSE_CYCLES : LOCK_STABLE_CYCLES;
   localparam int unsigned MaxCnt = (MaxAb > LOCK_TIMEOUT_CYCLES) ? MaxAb : LOCK_TIMEOUT_CYCLES;
   localparam int unsigned CntW   = $clog2(MaxCnt) + 1;

   // Terminal values compare against the count before increment, so the counter never has
   // to hold the parameter value itself.
   localparam logic [CntW-1:0] RstLast    = CntW'(RESET_PULSE_CYCLES - 1);
   localparam logic [CntW-1:0] StableLast = CntW'(LOCK_STABLE_CYCLES - 1);
   localparam logic [CntW-1:0] ToLast     = CntW'(LOCK_TIMEOUT_CYCLES - 1);
   localparam logic [1:0]      MaxRetry   = 2'(MAX_RETRIES);

   typedef enum logic [2:0] {
      StRstPll,
      StWaitLock,
      StStable,
      StRun,
      StFail
   } state_e;

   state_e          state_q, state_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic [1:0]      retry_q, retry_d;
   logic [5:0]      idsel_q, idsel_d;
   logic [5:0]      fbdsel_q, fbdsel_d;
   logic [5:0]      odsel_q, odsel_d;
   logic            armed_q, armed_d;
   logic            lock_meta_q, lock_s_q;
   logic            pll_reset_q, rst_out_q, locked_q, fail_q, cfg_ack_q;
   logic            accept;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      retry_d  = retry_q;
      idsel_d  = idsel_q;
      fbdsel_d = fbdsel_q;
      odsel_d  = odsel_q;

      accept = bus.cfg_req && armed_q && ((state_q == StRun) || (state_q == StFail));

      // A request must be seen low before another one can be accepted.
      armed_d = armed_q;
      if (!bus.cfg_req) begin
         armed_d = 1'b1;
      end
      if (accept) begin
         armed_d = 1'b0;
      end

      if (accept) begin
         // Takes priority over a simultaneous lock loss; both lead to one RST_PLL entry.
         idsel_d  = bus.cfg_idsel;
         fbdsel_d = bus.cfg_fbdsel;
         odsel_d  = bus.cfg_odsel;
         retry_d  = '0;
         cnt_d    = '0;
         state_d  = StRstPll;
      end else begin
         unique case (state_q)
            StRstPll: begin
               if (cnt_q == RstLast) begin
                  cnt_d   = '0;
                  state_d = StWaitLock;
               end else begin
                  cnt_d = cnt_q + CntW'(1);
               end
            end
            StWaitLock: begin
               if (lock_s_q) begin
                  cnt_d   = '0;
                  state_d = StStable;
               end else if (cnt_q == ToLast) begin
                  retry_d = retry_q + 2'd1;
                  cnt_d   = '0;
                  state_d = (retry_d == MaxRetry) ? StFail : StRstPll;
               end else begin
                  cnt_d = cnt_q + CntW'(1);
               end
            end
            StStable: begin
               if (!lock_s_q) begin
                  cnt_d   = '0;
                  state_d = StWaitLock;
               end else if (cnt_q == StableLast) begin
                  cnt_d   = '0;
                  state_d = StRun;
               end else begin
                  cnt_d = cnt_q + CntW'(1);
               end
            end
            StRun: begin
               if (!lock_s_q) begin
                  retry_d = '0;
                  cnt_d   = '0;
                  state_d = StRstPll;
               end
            end
            StFail: begin
               state_d = StFail;
            end
            default: begin
               cnt_d   = '0;
               state_d = StRstPll;
            end
         endcase
      end
   end

   always_ff @(posedge clkin or posedge reset) begin
      if (reset) begin
         lock_meta_q <= 1'b0;
         lock_s_q    <= 1'b0;
         state_q     <= StRstPll;
         cnt_q       <= '0;
         retry_q     <= '0;
         idsel_q     <= INIT_IDSEL;
         fbdsel_q    <= INIT_FBDSEL;
         odsel_q     <= INIT_ODSEL;
         armed_q     <= 1'b1;
         pll_reset_q <= 1'b1;
         rst_out_q   <= 1'b1;
         locked_q    <= 1'b0;
         fail_q      <= 1'b0;
         cfg_ack_q   <= 1'b0;
      end else begin
         lock_meta_q <= bus.pll_lock;
         lock_s_q    <= lock_meta_q;
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         retry_q     <= retry_d;
         idsel_q     <= idsel_d;
         fbdsel_q    <= fbdsel_d;
         odsel_q     <= odsel_d;
         armed_q     <= armed_d;
         pll_reset_q <= (state_d == StRstPll) || (state_d == StFail);
         rst_out_q   <= (state_d != StRun);
         locked_q    <= (state_d == StRun);
         fail_q      <= (state_d == StFail);
         cfg_ack_q   <= accept;
      end
   end

   assign bus.pll_reset  = pll_reset_q;
   assign bus.rst_out    = rst_out_q;
   assign bus.locked     = locked_q;
   assign bus.fail       = fail_q;
   assign bus.cfg_ack    = cfg_ack_q;
   assign bus.retry_cnt  = retry_q;
   assign bus.pll_idsel  = idsel_q;
   assign bus.pll_fbdsel = fbdsel_q;
   assign bus.pll_odsel  = odsel_q;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Bench for pll_lock_sequencer: a cycle-level reference model predicts every output vector
// into a queue and every divider acceptance into a second queue; a negedge monitor pops and
// compares. Directed phases cover the reset pulse, relock, glitch, failure, reconfiguration
// and mid-sequence reset; a randomized phase follows.
module tb_pll_lock_sequencer;
   localparam int RP = 4;
   localparam int ST = 8;
   localparam int TO = 32;
   localparam int MR = 3;
   localparam logic [17:0] InitDivs = 18'd0;
   // {pll_reset, rst_out, locked, fail, cfg_ack, retry_cnt, idsel, fbdsel, odsel}
   localparam logic [24:0] ResetVec = {5'b11000, 2'd0, InitDivs};

   logic clkin = 1'b0;
   logic reset = 1'b1;

   pll_lock_sequencer_if bus ();

   pll_lock_sequencer #(
      .RESET_PULSE_CYCLES (RP),
      .LOCK_STABLE_CYCLES (ST),
      .LOCK_TIMEOUT_CYCLES(TO),
      .MAX_RETRIES        (MR),
      .INIT_IDSEL         (6'd0),
      .INIT_FBDSEL        (6'd0),
      .INIT_ODSEL         (6'd0)
   ) dut (
      .clkin(clkin),
      .reset(reset),
      .bus  (bus)
   );

   always #5 clkin = ~clkin;

   int checks = 0;
   int errors = 0;

   logic [24:0] exp_q[$];
   logic [17:0] acc_q[$];

   typedef enum int {MRst, MWait, MStable, MRun, MFail} mphase_e;
   mphase_e     m_ph      = MRst;
   int          m_t       = 0;
   int          m_retries = 0;
   logic [17:0] m_divs    = InitDivs;
   logic        m_d1      = 1'b0;
   logic        m_d2      = 1'b0;
   logic        m_armed   = 1'b1;

   task automatic check(input string name, input logic [24:0] got, input logic [24:0] req);
      checks++;
      if (got !== req) begin
         errors++;
         $display("FAIL %s at %0t: got %h required %h", name, $time, got, req);
      end
   endtask

   function automatic logic [24:0] outputs_now();
      return {bus.pll_reset, bus.rst_out, bus.locked, bus.fail, bus.cfg_ack, bus.retry_cnt,
              bus.pll_idsel, bus.pll_fbdsel, bus.pll_odsel};
   endfunction

   task automatic model_reset();
      m_ph      = MRst;
      m_t       = 0;
      m_retries = 0;
      m_divs    = InitDivs;
      m_d1      = 1'b0;
      m_d2      = 1'b0;
      m_armed   = 1'b1;
      exp_q.delete();
      acc_q.delete();
   endtask

   // One clkin edge of the sequencer's behaviour: lock is seen two edges late, each phase
   // lasts a fixed number of edges, and the expected outputs follow from the phase reached.
   task automatic model_step();
      logic ls;
      logic acc;
      ls   = m_d2;
      m_d2 = m_d1;
      m_d1 = bus.pll_lock;
      acc  = bus.cfg_req && m_armed && (m_ph == MRun || m_ph == MFail);
      if (!bus.cfg_req) m_armed = 1'b1;
      if (acc) begin
         m_armed   = 1'b0;
         m_divs    = {bus.cfg_idsel, bus.cfg_fbdsel, bus.cfg_odsel};
         m_retries = 0;
         m_ph      = MRst;
         m_t       = 0;
         acc_q.push_back(m_divs);
      end else begin
         case (m_ph)
            MRst: begin
               m_t++;
               if (m_t == RP) begin m_ph = MWait; m_t = 0; end
            end
            MWait: begin
               if (ls) begin
                  m_ph = MStable;
                  m_t  = 0;
               end else begin
                  m_t++;
                  if (m_t == TO) begin
                     m_retries++;
                     m_t  = 0;
                     m_ph = (m_retries == MR) ? MFail : MRst;
                  end
               end
            end
            MStable: begin
               if (!ls) begin
                  m_ph = MWait;
                  m_t  = 0;
               end else begin
                  m_t++;
                  if (m_t == ST) begin m_ph = MRun; m_t = 0; end
               end
            end
            MRun: begin
               if (!ls) begin m_ph = MRst; m_t = 0; m_retries = 0; end
            end
            default: ;
         endcase
      end
      exp_q.push_back({(m_ph == MRst || m_ph == MFail), (m_ph != MRun), (m_ph == MRun),
                       (m_ph == MFail), acc, 2'(m_retries), m_divs});
   endtask

   initial begin
      forever begin
         @(posedge clkin or posedge reset);
         if (reset) model_reset();
         else model_step();
      end
   end

   initial begin
      logic [24:0] exp_v;
      logic [17:0] divs;
      forever begin
         @(negedge clkin);
         if (reset) begin
            check("reset_values", outputs_now(), ResetVec);
         end else begin
            if (exp_q.size() > 0) begin
               exp_v = exp_q.pop_front();
               check("cycle_outputs", outputs_now(), exp_v);
            end
            if (bus.cfg_ack) begin
               if (acc_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL cfg_ack_unexpected at %0t: got ack=1 required ack=0", $time);
               end else begin
                  divs = acc_q.pop_front();
                  check("cfg_dividers", 25'({bus.pll_idsel, bus.pll_fbdsel, bus.pll_odsel}),
                        25'(divs));
               end
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got no finish by %0t required finish", $time);
      $fatal(1, "watchdog expired");
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clkin);
         #1;
      end
   endtask

   task automatic wait_locked(input string name, input int budget);
      int k = 0;
      while (!bus.locked && k < budget) begin
         tick(1);
         k++;
      end
      check(name, 25'(bus.locked), 25'(1));
   endtask

   task automatic cfg_handshake(input logic [5:0] id, input logic [5:0] fb,
                                input logic [5:0] od, input int budget, input int hold);
      int k = 0;
      bus.cfg_idsel  = id;
      bus.cfg_fbdsel = fb;
      bus.cfg_odsel  = od;
      bus.cfg_req    = 1'b1;
      tick(1);
      while (!bus.cfg_ack && k < budget) begin
         tick(1);
         k++;
      end
      check("cfg_ack_seen", 25'(bus.cfg_ack), 25'(1));
      tick(hold);
      bus.cfg_req = 1'b0;
      tick(1);
   endtask

   initial begin
      int burst;
      bus.pll_lock   = 1'b0;
      bus.cfg_req    = 1'b0;
      bus.cfg_idsel  = '0;
      bus.cfg_fbdsel = '0;
      bus.cfg_odsel  = '0;
      tick(3);
      reset = 1'b0;

      // Lock appears at cycle 10 after release.
      tick(9);
      bus.pll_lock = 1'b1;
      wait_locked("first_lock", 40);
      check("first_lock_retry", 25'(bus.retry_cnt), 25'(0));
      tick(10);

      // Lock loss while running, then relock.
      bus.pll_lock = 1'b0;
      tick(3);
      check("lock_loss_outputs", 25'({bus.rst_out, bus.locked}), 25'(2'b10));
      bus.pll_lock = 1'b1;
      wait_locked("relock", 60);

      // Glitch during the stable window forces a full recount.
      bus.pll_lock = 1'b0;
      tick(6);
      bus.pll_lock = 1'b1;
      tick(6);
      bus.pll_lock = 1'b0;
      tick(3);
      bus.pll_lock = 1'b1;
      wait_locked("glitch_relock", 80);

      // No lock at all: three attempts then sticky failure.
      bus.pll_lock = 1'b0;
      tick(3 + 3 * (RP + TO) + 10);
      check("fail_state", 25'({bus.fail, bus.pll_reset, bus.locked, bus.retry_cnt}),
            25'({1'b1, 1'b1, 1'b0, 2'd3}));

      // Reconfigure out of failure.
      cfg_handshake(6'd6, 6'd25, 6'd4, 10, 0);
      check("cfg_from_fail", 25'({bus.pll_idsel, bus.pll_fbdsel, bus.pll_odsel, bus.fail}),
            25'({6'd6, 6'd25, 6'd4, 1'b0}));

      // Request raised in WAIT_LOCK stays pending until RUN, then held high without repeat.
      tick(5);
      bus.pll_lock = 1'b1;
      cfg_handshake(6'd10, 6'd20, 6'd30, 60, 40);
      wait_locked("relock_after_cfg", 60);

      // Request and lock loss together in RUN.
      bus.pll_lock = 1'b0;
      tick(2);
      cfg_handshake(6'd1, 6'd2, 6'd3, 5, 0);
      bus.pll_lock = 1'b1;
      wait_locked("relock_after_sim", 80);

      // Asynchronous reset in the middle of the stable window.
      bus.pll_lock = 1'b0;
      tick(8);
      bus.pll_lock = 1'b1;
      tick(9);
      #1;
      reset = 1'b1;
      #1;
      check("async_reset", outputs_now(), ResetVec);
      tick(3);
      reset = 1'b0;
      wait_locked("lock_after_reset", 60);

      // Randomized lock dropouts and reconfiguration requests.
      burst = 0;
      for (int i = 0; i < 1500; i++) begin
         if (burst > 0) begin
            burst--;
            if (burst == 0) bus.pll_lock = 1'b1;
         end else if ($urandom_range(99) == 0) begin
            bus.pll_lock = 1'b0;
            burst = ($urandom_range(3) == 0) ? int'($urandom_range(150, 40))
                                             : int'($urandom_range(12, 1));
         end
         if (bus.cfg_req && bus.cfg_ack) begin
            bus.cfg_req = 1'b0;
         end else if (!bus.cfg_req && $urandom_range(59) == 0) begin
            bus.cfg_idsel  = 6'($urandom);
            bus.cfg_fbdsel = 6'($urandom);
            bus.cfg_odsel  = 6'($urandom);
            bus.cfg_req    = 1'b1;
         end
         tick(1);
      end
      bus.cfg_req = 1'b0;
      tick(5);
      check("no_missing_acks", 25'(acc_q.size()), 25'(0));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
